// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg -- parametrised UART transmitter with a one-entry holding register.
//
// Sends each frame LSB first: a start bit, DATA_BITS data bits, an optional
// parity bit, then STOP_BITS stop bits. Every bit boundary falls on an external
// baud pulse. A word accepted during a frame waits in the holding register. It
// goes out back-to-back, starting on the pulse that ends the last stop bit.
//
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous reset, active low
//   pulse_tx    one-clk baud pulse; a bit lasts from one pulse to the next
//   tx_val      host word valid
//   tx_data     host word, taken when tx_val && tx_rdy
//   tx_rdy      holding register empty
//   tx          serial line, idle high
//   busy        frame in progress or word pending
//   frame_done  one-clk pulse when the last stop bit ends
//
// state    | meaning
// ---------+-----------------------------------------------
// S_IDLE   | line high, waiting for a pending word and a pulse
// S_START  | start bit (0) on the line
// S_DATA   | data bit bit_cnt on the line
// S_PARITY | parity bit on the line
// S_STOP   | stop bit stop_cnt on the line

module uart_tx_cfg #(
   parameter int DATA_BITS   = 8,
   parameter int PARITY_MODE = 0,
   parameter int STOP_BITS   = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 pulse_tx,
   input  logic                 tx_val,
   input  logic [DATA_BITS-1:0] tx_data,
   output logic                 tx_rdy,
   output logic                 tx,
   output logic                 busy,
   output logic                 frame_done
);

   localparam int CW = $clog2(DATA_BITS + 1);
   localparam bit PAR_EN  = (PARITY_MODE == 1) || (PARITY_MODE == 2);
   localparam logic PAR_ODD = (PARITY_MODE == 2);
   localparam logic [CW-1:0] LAST_BIT  = CW'(DATA_BITS - 1);
   localparam logic [CW-1:0] LAST_STOP = CW'(STOP_BITS - 1);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
   } state_t;

   state_t                 state_q, state_d;
   logic [DATA_BITS-1:0]   hold_q, hold_d;
   logic                   hold_valid_q, hold_valid_d;
   logic [DATA_BITS-1:0]   shift_q, shift_d;
   logic                   par_q, par_d;
   logic [CW-1:0]          bit_cnt_q, bit_cnt_d;
   logic [CW-1:0]          stop_cnt_q, stop_cnt_d;
   logic                   tx_q, tx_d;
   logic                   busy_q, busy_d;
   logic                   frame_done_q, frame_done_d;
   logic                   load;

   always_comb begin
      state_d      = state_q;
      hold_d       = hold_q;
      hold_valid_d = hold_valid_q;
      shift_d      = shift_q;
      par_d        = par_q;
      bit_cnt_d    = bit_cnt_q;
      stop_cnt_d   = stop_cnt_q;
      tx_d         = tx_q;
      frame_done_d = 1'b0;
      load         = 1'b0;

      // An accept can never coincide with a load: loading needs a full hold,
      // accepting needs an empty one.
      if (tx_val && !hold_valid_q) begin
         hold_d       = tx_data;
         hold_valid_d = 1'b1;
      end

      if (pulse_tx) begin
         unique case (state_q)
            S_IDLE: begin
               if (hold_valid_q) load = 1'b1;
            end
            S_START: begin
               tx_d      = shift_q[0];
               shift_d   = shift_q >> 1;
               bit_cnt_d = '0;
               state_d   = S_DATA;
            end
            S_DATA: begin
               if (bit_cnt_q == LAST_BIT) begin
                  if (PAR_EN) begin
                     tx_d    = par_q;
                     state_d = S_PARITY;
                  end else begin
                     tx_d       = 1'b1;
                     stop_cnt_d = '0;
                     state_d    = S_STOP;
                  end
               end else begin
                  tx_d      = shift_q[0];
                  shift_d   = shift_q >> 1;
                  bit_cnt_d = bit_cnt_q + CNT_ONE;
               end
            end
            S_PARITY: begin
               tx_d       = 1'b1;
               stop_cnt_d = '0;
               state_d    = S_STOP;
            end
            S_STOP: begin
               if (stop_cnt_q == LAST_STOP) begin
                  frame_done_d = 1'b1;
                  if (hold_valid_q) begin
                     load = 1'b1;
                  end else begin
                     tx_d    = 1'b1;
                     state_d = S_IDLE;
                  end
               end else begin
                  stop_cnt_d = stop_cnt_q + CNT_ONE;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end

      // Parity is fixed when the word is loaded, so the shift register can
      // consume the data bits freely.
      if (load) begin
         shift_d      = hold_q;
         par_d        = (^hold_q) ^ PAR_ODD;
         hold_valid_d = 1'b0;
         bit_cnt_d    = '0;
         tx_d         = 1'b0;
         state_d      = S_START;
      end

      busy_d = (state_d != S_IDLE) || hold_valid_d;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= S_IDLE;
         hold_q       <= '0;
         hold_valid_q <= 1'b0;
         shift_q      <= '0;
         par_q        <= 1'b0;
         bit_cnt_q    <= '0;
         stop_cnt_q   <= '0;
         tx_q         <= 1'b1;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         hold_q       <= hold_d;
         hold_valid_q <= hold_valid_d;
         shift_q      <= shift_d;
         par_q        <= par_d;
         bit_cnt_q    <= bit_cnt_d;
         stop_cnt_q   <= stop_cnt_d;
         tx_q         <= tx_d;
         busy_q       <= busy_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign tx_rdy     = ~hold_valid_q;
   assign tx         = tx_q;
   assign busy       = busy_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg. Four instances cover 8N1, 7E1, 7O2 and 9N1.
// Stimulus is a table of hand-computed frames plus sequences for back-to-back,
// reset, accept-on-pulse and held tx_val cases.
// A frame image has bit i equal to tx during the i-th bit period.

module tb_uart_tx_cfg;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       pulse_man = 1'b0;
   logic       pulse_free = 1'b0;
   logic       pulse_tx;
   logic [3:0] val = '0;
   logic [8:0] data_bus = '0;
   logic [3:0] tx_o, rdy_o, busy_o, done_o;

   int n_tests = 0;
   int n_fail  = 0;
   int sel     = 0;

   assign pulse_tx = pulse_man | pulse_free;

   always #5 clk = ~clk;

   uart_tx_cfg #(.DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) u_8n1 (
      .clk(clk), .rst(rst), .pulse_tx(pulse_tx), .tx_val(val[0]),
      .tx_data(data_bus[7:0]), .tx_rdy(rdy_o[0]), .tx(tx_o[0]),
      .busy(busy_o[0]), .frame_done(done_o[0]));

   uart_tx_cfg #(.DATA_BITS(7), .PARITY_MODE(1), .STOP_BITS(1)) u_7e1 (
      .clk(clk), .rst(rst), .pulse_tx(pulse_tx), .tx_val(val[1]),
      .tx_data(data_bus[6:0]), .tx_rdy(rdy_o[1]), .tx(tx_o[1]),
      .busy(busy_o[1]), .frame_done(done_o[1]));

   uart_tx_cfg #(.DATA_BITS(7), .PARITY_MODE(2), .STOP_BITS(2)) u_7o2 (
      .clk(clk), .rst(rst), .pulse_tx(pulse_tx), .tx_val(val[2]),
      .tx_data(data_bus[6:0]), .tx_rdy(rdy_o[2]), .tx(tx_o[2]),
      .busy(busy_o[2]), .frame_done(done_o[2]));

   uart_tx_cfg #(.DATA_BITS(9), .PARITY_MODE(0), .STOP_BITS(1)) u_9n1 (
      .clk(clk), .rst(rst), .pulse_tx(pulse_tx), .tx_val(val[3]),
      .tx_data(data_bus), .tx_rdy(rdy_o[3]), .tx(tx_o[3]),
      .busy(busy_o[3]), .frame_done(done_o[3]));

   typedef struct {
      int          cfg;
      logic [8:0]  data;
      int          len;
      logic [15:0] exp;
   } vec_t;

   vec_t vecs[9];

   // free-running baud pulse, one clk in four
   bit free_en = 1'b0;
   int fcnt = 0;
   always @(negedge clk) begin
      if (free_en) begin
         fcnt = (fcnt + 1) % 4;
         pulse_free = (fcnt == 0);
      end else begin
         pulse_free = 1'b0;
      end
   end

   // 8N1 line receiver: samples tx once per bit period, right after each pulse
   bit         mon_en = 1'b0;
   logic       pulse_d = 1'b0;
   bit         in_frame = 1'b0;
   int         bitn = 0;
   int         stop_err = 0;
   logic [7:0] sh = '0;
   logic [7:0] rxq[$];

   always @(posedge clk) pulse_d <= pulse_tx;

   always @(negedge clk) begin
      if (mon_en && pulse_d) begin
         if (!in_frame) begin
            if (tx_o[0] == 1'b0) begin
               in_frame = 1'b1;
               bitn = 0;
            end
         end else if (bitn < 8) begin
            sh[bitn] = tx_o[0];
            bitn++;
         end else begin
            if (tx_o[0] !== 1'b1) stop_err++;
            rxq.push_back(sh);
            in_frame = 1'b0;
         end
      end
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
      end
   endtask

   task automatic pulse_once(output logic t, output logic d);
      pulse_man = 1'b1;
      @(negedge clk);
      t = tx_o[sel];
      d = done_o[sel];
      pulse_man = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   // Accept one word, then step through the frame plus the pulse that ends it.
   task automatic run_frame(input int cfg, input logic [8:0] w, input int len,
                            input bit pulse_on_accept,
                            output logic [15:0] got, output int dones);
      logic t, d;
      sel = cfg;
      data_bus = w;
      val[cfg] = 1'b1;
      if (pulse_on_accept) pulse_man = 1'b1;
      @(negedge clk);
      val[cfg] = 1'b0;
      pulse_man = 1'b0;
      check("accept_busy", busy_o[cfg], 1);
      check("accept_rdy", rdy_o[cfg], 0);
      check("accept_tx_idle", tx_o[cfg], 1);
      repeat (2) @(negedge clk);
      got = '0;
      dones = 0;
      for (int i = 0; i <= len; i++) begin
         pulse_once(t, d);
         if (i < len) got[i] = t;
         dones += int'(d);
      end
   endtask

   initial begin
      logic [15:0] got;
      logic [19:0] got20;
      int          dones;
      logic        t, d;
      bit          rdy_bad;
      logic [7:0]  words[32];
      int          k, budget;
      logic        acc;

      vecs[0] = '{0, 9'h0A5, 10, 16'b000000_1101001010};
      vecs[1] = '{0, 9'h000, 10, 16'b000000_1000000000};
      vecs[2] = '{0, 9'h0FF, 10, 16'b000000_1111111110};
      vecs[3] = '{1, 9'h035, 10, 16'b000000_1001101010};
      vecs[4] = '{1, 9'h001, 10, 16'b000000_1100000010};
      vecs[5] = '{2, 9'h035, 11, 16'b00000_11101101010};
      vecs[6] = '{2, 9'h000, 11, 16'b00000_11100000000};
      vecs[7] = '{3, 9'h1FF, 11, 16'b00000_11111111110};
      vecs[8] = '{3, 9'h100, 11, 16'b00000_11000000000};

      repeat (2) @(negedge clk);
      for (int c = 0; c < 4; c++) begin
         check($sformatf("reset_tx_%0d", c), tx_o[c], 1);
         check($sformatf("reset_rdy_%0d", c), rdy_o[c], 1);
         check($sformatf("reset_busy_%0d", c), busy_o[c], 0);
         check($sformatf("reset_done_%0d", c), done_o[c], 0);
      end
      rst = 1'b1;
      @(negedge clk);

      // table of single frames
      for (int v = 0; v < 9; v++) begin
         run_frame(vecs[v].cfg, vecs[v].data, vecs[v].len, 1'b0, got, dones);
         check($sformatf("frame_v%0d", v), got, vecs[v].exp);
         check($sformatf("done_count_v%0d", v), dones, 1);
         check($sformatf("busy_after_v%0d", v), busy_o[vecs[v].cfg], 0);
         check($sformatf("rdy_after_v%0d", v), rdy_o[vecs[v].cfg], 1);
      end

      // back-to-back: 0x55 then 0xF0 accepted during DATA
      sel = 0;
      data_bus = 9'h055;
      val[0] = 1'b1;
      @(negedge clk);
      val[0] = 1'b0;
      repeat (2) @(negedge clk);
      got20 = '0;
      dones = 0;
      rdy_bad = 1'b0;
      for (int i = 0; i < 2; i++) begin
         pulse_once(t, d);
         got20[i] = t;
         dones += int'(d);
      end
      data_bus = 9'h0F0;
      val[0] = 1'b1;
      @(negedge clk);
      val[0] = 1'b0;
      check("b2b_rdy_after_accept", rdy_o[0], 0);
      for (int i = 2; i <= 20; i++) begin
         pulse_once(t, d);
         if (i < 20) got20[i] = t;
         dones += int'(d);
         if (i < 10 && rdy_o[0] !== 1'b0) rdy_bad = 1'b1;
         if (i == 10) check("b2b_rdy_at_second_start", rdy_o[0], 1);
      end
      check("b2b_rdy_held_low", rdy_bad, 0);
      check("b2b_frames", got20, 20'b1_11110000_0_1_01010101_0);
      check("b2b_done_count", dones, 2);
      check("b2b_busy_after", busy_o[0], 0);

      // 9N1 with a pulse on the accept edge: start waits for the next pulse
      run_frame(3, 9'h1FF, 11, 1'b1, got, dones);
      check("pulse_on_accept_frame", got, 16'b00000_11111111110);
      check("pulse_on_accept_done", dones, 1);

      // asynchronous reset mid-DATA with a word pending
      sel = 0;
      data_bus = 9'h012;
      val[0] = 1'b1;
      @(negedge clk);
      val[0] = 1'b0;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 4; i++) pulse_once(t, d);
      data_bus = 9'h034;
      val[0] = 1'b1;
      @(negedge clk);
      val[0] = 1'b0;
      check("rst_tx_low_before", tx_o[0], 0);
      check("rst_pending_before", rdy_o[0], 0);
      #2 rst = 1'b0;
      #1;
      check("rst_async_tx", tx_o[0], 1);
      check("rst_async_busy", busy_o[0], 0);
      check("rst_async_rdy", rdy_o[0], 1);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      run_frame(0, 9'h03C, 10, 1'b0, got, dones);
      check("post_rst_frame", got, 16'b000000_1001111000);
      check("post_rst_done", dones, 1);

      // 32 random words with tx_val held high until accepted
      for (int i = 0; i < 32; i++) words[i] = 8'($urandom);
      mon_en = 1'b1;
      free_en = 1'b1;
      sel = 0;
      k = 0;
      budget = 0;
      data_bus = {1'b0, words[0]};
      val[0] = 1'b1;
      while (k < 32 && budget < 4000) begin
         acc = rdy_o[0];
         @(negedge clk);
         budget++;
         if (acc) begin
            k++;
            if (k < 32) data_bus = {1'b0, words[k]};
            else val[0] = 1'b0;
         end
      end
      val[0] = 1'b0;
      check("held_val_all_accepted", k, 32);
      while (rxq.size() < 32 && budget < 6000) begin
         @(negedge clk);
         budget++;
      end
      repeat (50) @(negedge clk);
      check("held_val_rx_count", rxq.size(), 32);
      check("held_val_stop_bits", stop_err, 0);
      for (int i = 0; i < 32; i++) begin
         if (i < rxq.size()) check($sformatf("held_val_word_%0d", i), rxq[i], words[i]);
      end
      free_en = 1'b0;
      mon_en = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
